laser_pool: RTL and testbench

//  Multi-shot player laser manager: NUM_LASERS independent slots, each able to hold one laser in flight.

---
 rtl/laser_pool_if.sv | 43 ++++
 rtl/laser_pool.sv | 223 ++++++++++++++++++++++
 tb/tb_laser_pool.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/laser_pool_if.sv
// -----------------------------------------------------------------------------
// laser_pool_if
// Purpose : bundles the per-frame control, collision and pixel signals that go
//           between the gun/ship/VGA side (master) and laser_pool (slave).
// Parameters:
//   NUM_LASERS      number of laser slots carried by the mask/position buses
// Signals (i_ = into laser_pool, o_ = out of laser_pool):
//   i_enable        motion tick, one-cycle pulse per frame step
//   i_fire          fire request from the player
//   i_gunPosition   x of the gun centre
//   i_killMask      bit i: slot i hit an alien this cycle
//   i_hPos, i_vPos  pixel currently being drawn
//   o_aliveMask     bit i: slot i in flight
//   o_xLasers       slot i x at [10*i+9:10*i]
//   o_yLasers       slot i y, same packing
//   o_colorLaser    colour of the pixel presented one cycle earlier
// -----------------------------------------------------------------------------
interface laser_pool_if #(
  parameter int NUM_LASERS = 4
);
  logic                       i_enable;
  logic                       i_fire;
  logic [9:0]                 i_gunPosition;
  logic [NUM_LASERS-1:0]      i_killMask;
  logic [9:0]                 i_hPos;
  logic [9:0]                 i_vPos;
  logic [NUM_LASERS-1:0]      o_aliveMask;
  logic [10*NUM_LASERS-1:0]   o_xLasers;
  logic [10*NUM_LASERS-1:0]   o_yLasers;
  logic [2:0]                 o_colorLaser;

  // Controller / collision / VGA side
  modport master (
    output i_enable, i_fire, i_gunPosition, i_killMask, i_hPos, i_vPos,
    input  o_aliveMask, o_xLasers, o_yLasers, o_colorLaser
  );

  // Laser manager side
  modport slave (
    input  i_enable, i_fire, i_gunPosition, i_killMask, i_hPos, i_vPos,
    output o_aliveMask, o_xLasers, o_yLasers, o_colorLaser
  );
endinterface

// File: rtl/laser_pool.sv
// -----------------------------------------------------------------------------
// laser_pool
// Purpose : multi-shot player laser manager. NUM_LASERS independent slots each
//           hold at most one laser in flight. Shots are rate limited by a
//           cooldown counter, slots can be killed by the alien collision logic,
//           and a registered colour is produced for the VGA colour mux.
// Ports   :
//   i_clk     system clock
//   i_reset   synchronous, active-high reset (priority over everything)
//   bus       laser_pool_if.slave: enable/fire/gunPosition/killMask/hPos/vPos
//             in; aliveMask/xLasers/yLasers/colorLaser out
// Configuration:
//   LASER_AUTOFIRE_EN  when defined, fire is level sensitive and holding it
//                      re-fires whenever the cooldown has expired and a slot
//                      is free. When undefined, only a rising edge of fire is a
//                      request; an edge arriving during cooldown is lost.
// -----------------------------------------------------------------------------
module laser_pool #(
  parameter int         NUM_LASERS    = 4,
  parameter int         COOLDOWN      = 16,
  parameter int         STEP_MOTION   = 1,
  parameter int         RADIUS        = 7,
  parameter int         SCREEN_WIDTH  = 640,
  parameter int         SCREEN_HEIGHT = 480,
  parameter int         SHIP_HEIGHT   = 30,
  parameter int         V_OFFSET      = 10,
  parameter logic [2:0] BACKGROUND    = 3'd0,
  parameter logic [2:0] LASER         = 3'd3,
  parameter logic [2:0] KILL          = 3'd1
) (
  input logic          i_clk,
  input logic          i_reset,
  laser_pool_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int              CW        = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [9:0]      PARK_X    = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]      PARK_Y    = 10'(SCREEN_HEIGHT - 1);
  localparam logic [9:0]      START_Y   = 10'(SCREEN_HEIGHT - V_OFFSET - SHIP_HEIGHT - RADIUS);
  localparam logic [9:0]      STEP      = 10'(STEP_MOTION);
  localparam logic [21:0]     RADIUS_SQ = 22'(RADIUS * RADIUS);
  localparam logic [CW-1:0]   COOL_LOAD = CW'(COOLDOWN);
  localparam logic [CW-1:0]   COOL_ZERO = CW'(0);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Square of the signed 11-bit difference a-b. |a-b| <= 1023 so the square
  // fits in 20 bits; a 21-bit result leaves headroom and never wraps.
  function automatic logic [20:0] diff_sq(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    logic [9:0]         m;
    logic [20:0]        m_ext;
    d     = $signed({1'b0, a}) - $signed({1'b0, b});
    m     = d[10] ? 10'(-d) : d[9:0];
    m_ext = 21'(m);
    return m_ext * m_ext;
  endfunction

  // True when pixel (h,v) is strictly inside the disc centred on (x,y).
  function automatic logic in_disc(input logic [9:0] h, input logic [9:0] v,
                                   input logic [9:0] x, input logic [9:0] y);
    logic [21:0] sum;
    sum = 22'(diff_sq(h, x)) + 22'(diff_sq(v, y));
    return (sum < RADIUS_SQ);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_LASERS-1:0] r_alive;
  logic [9:0]            r_x [NUM_LASERS];
  logic [9:0]            r_y [NUM_LASERS];
  logic [CW-1:0]         r_cool;
  logic [2:0]            r_color;

  // ---------------------------------------------------------------------------
  // Next-state / combinational signals
  // ---------------------------------------------------------------------------
  logic                    w_fire_req;
  logic [NUM_LASERS-1:0]   w_grant;
  logic                    w_any_free;
  logic                    w_accept;
  logic [NUM_LASERS-1:0]   w_alive_nx;
  logic [9:0]              w_x_nx [NUM_LASERS];
  logic [9:0]              w_y_nx [NUM_LASERS];
  logic [CW-1:0]           w_cool_nx;
  logic [NUM_LASERS-1:0]   w_hit;
  logic [2:0]              w_color_nx;
  logic [10*NUM_LASERS-1:0] w_x_flat;
  logic [10*NUM_LASERS-1:0] w_y_flat;

`ifdef LASER_AUTOFIRE_EN
  // Level-sensitive request: holding fire keeps asking for shots.
  assign w_fire_req = bus.i_fire;
`else
  logic r_fire_q;

  // Previous fire level, used to detect rising edges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fire_q <= 1'b0;
    end else begin
      r_fire_q <= bus.i_fire;
    end
  end

  // Only a fresh press counts as a request.
  assign w_fire_req = bus.i_fire & ~r_fire_q;
`endif

  // Lowest dead slot as a one-hot grant: isolating the lowest zero of r_alive.
  // This looks only at start-of-cycle state, so a slot freed this cycle is not
  // reusable until the next one.
  assign w_grant    = ~r_alive & (r_alive + NUM_LASERS'(1));
  assign w_any_free = |(~r_alive);
  assign w_accept   = w_fire_req & (r_cool == COOL_ZERO) & w_any_free;

  // Per-slot next state: allocate, then kill > motion for live slots.
  always_comb begin
    w_alive_nx = r_alive;
    for (int i = 0; i < NUM_LASERS; i++) begin
      w_x_nx[i] = r_x[i];
      w_y_nx[i] = r_y[i];
      if (w_accept && w_grant[i]) begin
        // A granted slot is dead at cycle start, so kill/motion cannot apply.
        w_alive_nx[i] = 1'b1;
        w_x_nx[i]     = bus.i_gunPosition;
        w_y_nx[i]     = START_Y;
      end else if (r_alive[i] && bus.i_killMask[i]) begin
        w_alive_nx[i] = 1'b0;
        w_x_nx[i]     = PARK_X;
        w_y_nx[i]     = PARK_Y;
      end else if (r_alive[i] && bus.i_enable) begin
        if (r_y[i] > STEP) begin
          w_y_nx[i] = r_y[i] - STEP;
        end else begin
          // Would leave the top of the screen: retire the slot.
          w_alive_nx[i] = 1'b0;
          w_x_nx[i]     = PARK_X;
          w_y_nx[i]     = PARK_Y;
        end
      end else begin
        w_alive_nx[i] = r_alive[i];
        w_x_nx[i]     = r_x[i];
        w_y_nx[i]     = r_y[i];
      end
    end
  end

  // Cooldown: a new shot reloads it even if a tick arrives in the same cycle.
  always_comb begin
    w_cool_nx = r_cool;
    if (w_accept) begin
      w_cool_nx = COOL_LOAD;
    end else if (bus.i_enable && (r_cool != COOL_ZERO)) begin
      w_cool_nx = r_cool - CW'(1);
    end else begin
      w_cool_nx = r_cool;
    end
  end

  // Pixel hit test against start-of-cycle slot state; dead slots never render.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_LASERS; i++) begin
      w_hit[i] = r_alive[i] & in_disc(bus.i_hPos, bus.i_vPos, r_x[i], r_y[i]);
    end
  end

  // Colour select: a hit on a slot being killed this cycle shows KILL.
  always_comb begin
    w_color_nx = BACKGROUND;
    if (|(w_hit & bus.i_killMask)) begin
      w_color_nx = KILL;
    end else if (|w_hit) begin
      w_color_nx = LASER;
    end else begin
      w_color_nx = BACKGROUND;
    end
  end

  // Main state register with synchronous reset parking every slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_alive <= '0;
      for (int i = 0; i < NUM_LASERS; i++) begin
        r_x[i] <= PARK_X;
        r_y[i] <= PARK_Y;
      end
      r_cool  <= COOL_ZERO;
      r_color <= BACKGROUND;
    end else begin
      r_alive <= w_alive_nx;
      for (int i = 0; i < NUM_LASERS; i++) begin
        r_x[i] <= w_x_nx[i];
        r_y[i] <= w_y_nx[i];
      end
      r_cool  <= w_cool_nx;
      r_color <= w_color_nx;
    end
  end

  // Pack per-slot position registers onto the flat output buses.
  always_comb begin
    w_x_flat = '0;
    w_y_flat = '0;
    for (int i = 0; i < NUM_LASERS; i++) begin
      w_x_flat[10*i +: 10] = r_x[i];
      w_y_flat[10*i +: 10] = r_y[i];
    end
  end

  assign bus.o_aliveMask  = r_alive;
  assign bus.o_xLasers    = w_x_flat;
  assign bus.o_yLasers    = w_y_flat;
  assign bus.o_colorLaser = r_color;

endmodule

// File: tb/tb_laser_pool.sv
// -----------------------------------------------------------------------------
// tb_laser_pool
// Directed testbench for laser_pool at default parameters. Inputs change and
// outputs are sampled on the falling clock edge. Expected values are worked
// out by hand from the laser behaviour (START_Y = 433, cooldown 16 ticks).
// -----------------------------------------------------------------------------
module tb_laser_pool;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  laser_pool_if #(.NUM_LASERS(N)) bus ();

  laser_pool #(.NUM_LASERS(N)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xs(input int i);
    return 32'(bus.o_xLasers[10*i +: 10]);
  endfunction

  function automatic logic [31:0] ys(input int i);
    return 32'(bus.o_yLasers[10*i +: 10]);
  endfunction

  // One clock cycle with the given enable/fire/kill inputs.
  task automatic step(input logic en, input logic fr, input logic [3:0] km);
    bus.i_enable   = en;
    bus.i_fire     = fr;
    bus.i_killMask = km;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.i_enable   = 1'b0;
    bus.i_fire     = 1'b0;
    bus.i_killMask = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sixteen enable ticks with no fire: expires a freshly loaded cooldown.
  task automatic wait_cool();
    repeat (16) step(1'b1, 1'b0, 4'b0000);
  endtask

  initial begin
    reset             = 1'b1;
    bus.i_enable      = 1'b0;
    bus.i_fire        = 1'b0;
    bus.i_gunPosition = 10'd0;
    bus.i_killMask    = 4'b0000;
    bus.i_hPos        = 10'd0;
    bus.i_vPos        = 10'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset state, then held with idle inputs
    check("rst_alive", 32'(bus.o_aliveMask), 32'd0);
    check("rst_color", 32'(bus.o_colorLaser), 32'd0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_x%0d", i), xs(i), 32'd639);
      check($sformatf("rst_y%0d", i), ys(i), 32'd479);
    end
    repeat (10) step(1'b0, 1'b0, 4'b0000);
    check("idle_alive", 32'(bus.o_aliveMask), 32'd0);
    check("idle_x0", xs(0), 32'd639);
    check("idle_y3", ys(3), 32'd479);
    check("idle_color", 32'(bus.o_colorLaser), 32'd0);

    // 2: single shot, motion and pixel test
    bus.i_gunPosition = 10'd100;
    step(1'b0, 1'b1, 4'b0000);
    check("shot_alive", 32'(bus.o_aliveMask), 32'd1);
    check("shot_x0", xs(0), 32'd100);
    check("shot_y0", ys(0), 32'd433);
    repeat (5) step(1'b1, 1'b0, 4'b0000);
    check("move_y0", ys(0), 32'd428);
    bus.i_hPos = 10'd100; bus.i_vPos = 10'd428;
    step(1'b0, 1'b0, 4'b0000);
    check("pix_centre", 32'(bus.o_colorLaser), 32'd3);
    bus.i_hPos = 10'd106;
    step(1'b0, 1'b0, 4'b0000);
    check("pix_dx6", 32'(bus.o_colorLaser), 32'd3);
    bus.i_hPos = 10'd108;
    step(1'b0, 1'b0, 4'b0000);
    check("pix_dx8", 32'(bus.o_colorLaser), 32'd0);
    bus.i_hPos = 10'd100; bus.i_vPos = 10'd435;
    step(1'b0, 1'b0, 4'b0000);
    check("pix_dy7_edge", 32'(bus.o_colorLaser), 32'd0);
    bus.i_hPos = 10'd0; bus.i_vPos = 10'd0;

    // 3: cooldown of 16 enable ticks between accepted shots
    do_reset();
    bus.i_gunPosition = 10'd200;
    step(1'b0, 1'b1, 4'b0000);
    check("cd_first", 32'(bus.o_aliveMask), 32'd1);
    bus.i_gunPosition = 10'd300;
    repeat (16) begin
      step(1'b1, 1'b1, 4'b0000);
      step(1'b0, 1'b0, 4'b0000);
    end
    check("cd_blocked", 32'(bus.o_aliveMask), 32'd1);
    step(1'b1, 1'b1, 4'b0000);
    check("cd_second", 32'(bus.o_aliveMask), 32'd3);
    check("cd_x1", xs(1), 32'd300);
    check("cd_y1", ys(1), 32'd433);
    check("cd_x0", xs(0), 32'd200);
    check("cd_y0", ys(0), 32'd416);

    // 4: fill all slots, drop when full, kill and reuse
    wait_cool();
    bus.i_gunPosition = 10'd400;
    step(1'b0, 1'b1, 4'b0000);
    check("fill3", 32'(bus.o_aliveMask), 32'd7);
    check("fill3_x2", xs(2), 32'd400);
    wait_cool();
    bus.i_gunPosition = 10'd500;
    step(1'b0, 1'b1, 4'b0000);
    check("fill4", 32'(bus.o_aliveMask), 32'd15);
    wait_cool();
    check("full_y0", ys(0), 32'd368);
    check("full_y3", ys(3), 32'd417);
    bus.i_gunPosition = 10'd50;
    step(1'b0, 1'b1, 4'b0000);
    check("drop_alive", 32'(bus.o_aliveMask), 32'd15);
    check("drop_x3", xs(3), 32'd500);
    step(1'b0, 1'b0, 4'b0010);
    check("kill1_alive", 32'(bus.o_aliveMask), 32'd13);
    check("kill1_x1", xs(1), 32'd639);
    check("kill1_y1", ys(1), 32'd479);
    check("kill1_y0", ys(0), 32'd368);
    bus.i_gunPosition = 10'd60;
    step(1'b0, 1'b1, 4'b0000);
    check("reuse1_alive", 32'(bus.o_aliveMask), 32'd15);
    check("reuse1_x1", xs(1), 32'd60);
    check("reuse1_y1", ys(1), 32'd433);
    wait_cool();
    step(1'b0, 1'b1, 4'b0001);
    check("freed_not_reused", 32'(bus.o_aliveMask), 32'd14);
    check("freed_x0", xs(0), 32'd639);
    step(1'b0, 1'b0, 4'b0000);
    bus.i_gunPosition = 10'd70;
    step(1'b0, 1'b1, 4'b0000);
    check("reuse0_alive", 32'(bus.o_aliveMask), 32'd15);
    check("reuse0_x0", xs(0), 32'd70);
    check("reuse0_y0", ys(0), 32'd433);

    // 5: top-of-screen retire, kill beats motion, kill colour
    do_reset();
    bus.i_gunPosition = 10'd320;
    step(1'b0, 1'b1, 4'b0000);
    repeat (432) step(1'b1, 1'b0, 4'b0000);
    check("top_y1", ys(0), 32'd1);
    check("top_alive", 32'(bus.o_aliveMask), 32'd1);
    step(1'b1, 1'b0, 4'b0000);
    check("top_freed", 32'(bus.o_aliveMask), 32'd0);
    check("top_park_x", xs(0), 32'd639);
    check("top_park_y", ys(0), 32'd479);
    step(1'b0, 1'b1, 4'b0000);
    check("refire_y0", ys(0), 32'd433);
    repeat (3) step(1'b1, 1'b0, 4'b0000);
    check("refire_move", ys(0), 32'd430);
    bus.i_hPos = 10'd320; bus.i_vPos = 10'd430;
    step(1'b1, 1'b0, 4'b0001);
    check("kill_color", 32'(bus.o_colorLaser), 32'd1);
    check("kill_alive", 32'(bus.o_aliveMask), 32'd0);
    check("kill_nomove_y", ys(0), 32'd479);
    bus.i_hPos = 10'd639; bus.i_vPos = 10'd479;
    step(1'b0, 1'b0, 4'b0000);
    check("parked_no_render", 32'(bus.o_colorLaser), 32'd0);
    bus.i_hPos = 10'd0; bus.i_vPos = 10'd0;

    // 6: holding fire for 100 ticks
    do_reset();
    bus.i_gunPosition = 10'd150;
    repeat (100) step(1'b1, 1'b1, 4'b0000);
    check("hold_y0", ys(0), 32'd334);
`ifdef LASER_AUTOFIRE_EN
    check("hold_autofire", 32'(bus.o_aliveMask), 32'd15);
`else
    check("hold_single", 32'(bus.o_aliveMask), 32'd1);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0000);
    check("hold_repress", 32'(bus.o_aliveMask), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
